// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end: program memory, load sequencing, and the PC.
// The controller must qualify every architectural write with run_enable;
// instruction is presented in every state, so the state alone is not enough.
//
// state  | meaning
// -------+------------------------------------------------------------
// LOAD   | accepting program words, load_ready high
// WAIT   | program loaded, waiting for start or reload
// RUN    | executing; PC follows next_address unless hold is high
// HALT   | branch-to-self seen; waiting for start or reload
module instruction_fetch_unit #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          start,
  input  logic          reload,
  input  logic          hold,
  input  logic [AW-1:0] next_address,
  output logic [IW-1:0] instruction,
  output logic [AW-1:0] current_address,
  output logic          run_enable,
  output logic          halted,
  output logic [AW:0]   load_count
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // Index of the final word the memory can hold; accepting it ends the load.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] pc;
  logic [IW-1:0] mem [DEPTH];

  logic wr_en;
  logic cnt_clr;
  logic pc_zero;
  logic pc_adv;

  // Next-state and per-cycle control decode.
  // load_count doubles as the write pointer: it can never reach DEPTH while
  // in LOAD, because accepting the last slot moves straight to WAIT.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    cnt_clr  = 1'b0;
    pc_zero  = 1'b0;
    pc_adv   = 1'b0;
    case (state)
      S_LOAD: begin
        if (load_valid) begin
          wr_en = 1'b1;
          if (load_last || (load_count == LAST_IDX)) state_nx = S_WAIT;
        end
      end
      S_WAIT, S_HALT: begin
        if (reload) begin
          cnt_clr  = 1'b1;
          state_nx = S_LOAD;
        end else if (start) begin
          pc_zero  = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        // A branch-to-self halts without moving the PC, so that instruction
        // commits exactly once.
        if (!hold) begin
          if (next_address == pc) state_nx = S_HALT;
          else                    pc_adv   = 1'b1;
        end
      end
      default: state_nx = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nx;
  end

  // Program counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       pc <= '0;
    else if (pc_zero) pc <= '0;
    else if (pc_adv)  pc <= next_address;
  end

  // Accepted-word count, also used as the memory write pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       load_count <= '0;
    else if (cnt_clr) load_count <= '0;
    else if (wr_en)   load_count <= load_count + 1'b1;
  end

  // Program memory; cleared by reset only, a reload just overwrites.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[load_count[AW-1:0]] <= load_data;
    end
  end

  // Outputs decoded from registered state; run_enable also follows hold.
  always_comb begin
    load_ready      = (state == S_LOAD);
    halted          = (state == S_HALT);
    run_enable      = (state == S_RUN) && !hold;
    current_address = pc;
    instruction     = mem[pc];
  end

endmodule
